// File: rtl/wdt_apb_servicer.sv
// Autonomous APB initiator that initialises a watchdog (TORR, CR), then kicks CRR
// on a fixed period while a heartbeat keeps it armed, and clears interrupts via EOI.
module wdt_apb_servicer #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [7:0]        TORR_VAL    = 8'h00,
  parameter logic [5:0]        CR_VAL      = 6'h01,
  parameter logic [31:0]       KICK_PERIOD = 32'd1000
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              heartbeat,
  input  logic              wdt_int,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              init_done,
  output logic              kick_pulse,
  output logic              eoi_pulse,
  output logic [7:0]        missed_cnt,
  output logic              err
);

  localparam logic [ADDR_W-1:0] A_CR    = BASE_ADDR;
  localparam logic [ADDR_W-1:0] A_TORR  = BASE_ADDR + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CRR   = BASE_ADDR + ADDR_W'(12);
  localparam logic [ADDR_W-1:0] A_EOI   = BASE_ADDR + ADDR_W'(20);
  localparam logic [31:0]       CRR_KEY = 32'h0000_0076;
  localparam logic [31:0]       RELOAD  = KICK_PERIOD - 32'd1;

  typedef enum logic [2:0] {INIT_TORR, INIT_CR, IDLE, SETUP, ACCESS} state_t;
  typedef enum logic [1:0] {X_TORR, X_CR, X_CRR, X_EOI} xfer_t;

  state_t            state_q, state_d;
  xfer_t             xfer_q, xfer_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              init_done_q, init_done_d;
  logic              kick_pulse_q, kick_pulse_d;
  logic              eoi_pulse_q, eoi_pulse_d;
  logic [7:0]        missed_q, missed_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;
  logic              kick_req_q, kick_req_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [1:0]        holdoff_q, holdoff_d;

  logic              crr_start;
  logic              crr_done;
  logic              eoi_done;
  logic              expiry;

  // Read data carries nothing this block needs; the read only has to complete.
  logic              unused_prdata;
  assign unused_prdata = ^prdata;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Bus sequencer. INIT_CR doubles as the setup phase of the CR write so the two
  // init transfers run back to back without an idle cycle between them.
  always_comb begin
    state_d      = state_q;
    xfer_d       = xfer_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    init_done_d  = init_done_q;
    kick_pulse_d = 1'b0;
    eoi_pulse_d  = 1'b0;
    err_d        = err_q;
    crr_start    = 1'b0;
    crr_done     = 1'b0;
    eoi_done     = 1'b0;
    case (state_q)
      INIT_TORR: begin
        state_d   = SETUP;
        xfer_d    = X_TORR;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = 1'b1;
        paddr_d   = A_TORR;
        pwdata_d  = {24'h0, TORR_VAL};
      end
      INIT_CR, SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          if (pslverr) err_d = 1'b1;
          if (xfer_q == X_TORR) begin
            state_d   = INIT_CR;
            xfer_d    = X_CR;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = 1'b1;
            paddr_d   = A_CR;
            pwdata_d  = {26'h0, CR_VAL};
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
          case (xfer_q)
            X_CR:    init_done_d  = 1'b1;
            X_CRR:   begin kick_pulse_d = 1'b1; crr_done = 1'b1; end
            X_EOI:   begin eoi_pulse_d  = 1'b1; eoi_done = 1'b1; end
            default: ;
          endcase
        end
      end
      IDLE: begin
        // Interrupt clearing outranks a pending kick.
        if (wdt_int && (holdoff_q == 2'd0)) begin
          state_d   = SETUP;
          xfer_d    = X_EOI;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          paddr_d   = A_EOI;
          pwdata_d  = 32'h0;
        end else if (kick_req_q) begin
          state_d   = SETUP;
          xfer_d    = X_CRR;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = 1'b1;
          paddr_d   = A_CRR;
          pwdata_d  = CRR_KEY;
          crr_start = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Kick scheduling: period counter, arming, pending request, miss count, holdoff.
  always_comb begin
    expiry     = init_done_q && (cnt_q == 32'd0);
    cnt_d      = cnt_q;
    if (init_done_q) cnt_d = (cnt_q == 32'd0) ? RELOAD : cnt_q - 32'd1;
    armed_d    = heartbeat | (armed_q & ~crr_done);
    // A kick entering SETUP consumes the request; an expiry in that same cycle
    // is covered by the kick already on its way.
    kick_req_d = crr_start ? 1'b0 : (kick_req_q | (expiry & armed_q));
    missed_d   = (expiry && !armed_q) ? sat_inc8(missed_q) : missed_q;
    holdoff_d  = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
    if (eoi_done) holdoff_d = 2'd2;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q      <= INIT_TORR;
      xfer_q       <= X_TORR;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= 32'h0;
      init_done_q  <= 1'b0;
      kick_pulse_q <= 1'b0;
      eoi_pulse_q  <= 1'b0;
      missed_q     <= 8'h0;
      err_q        <= 1'b0;
      armed_q      <= 1'b0;
      kick_req_q   <= 1'b0;
      cnt_q        <= RELOAD;
      holdoff_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      xfer_q       <= xfer_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      init_done_q  <= init_done_d;
      kick_pulse_q <= kick_pulse_d;
      eoi_pulse_q  <= eoi_pulse_d;
      missed_q     <= missed_d;
      err_q        <= err_d;
      armed_q      <= armed_d;
      kick_req_q   <= kick_req_d;
      cnt_q        <= cnt_d;
      holdoff_q    <= holdoff_d;
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign init_done  = init_done_q;
  assign kick_pulse = kick_pulse_q;
  assign eoi_pulse  = eoi_pulse_q;
  assign missed_cnt = missed_q;
  assign err        = err_q;

endmodule

// File: tb/tb_wdt_apb_servicer.sv
// Bench for wdt_apb_servicer: init vector table, APB scoreboard of expected
// transfers, and hand-written kick / EOI / error / reset sequences.
module tb_wdt_apb_servicer;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        heartbeat = 1'b0;
  logic        wdt_int = 1'b0;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        init_done, kick_pulse, eoi_pulse, err;
  logic [7:0]  missed_cnt;

  always #5 pclk = ~pclk;

  wdt_apb_servicer #(
    .ADDR_W(8), .BASE_ADDR(8'h00), .TORR_VAL(8'h00), .CR_VAL(6'h01), .KICK_PERIOD(32'd16)
  ) dut (
    .pclk(pclk), .prst(prst), .heartbeat(heartbeat), .wdt_int(wdt_int),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .init_done(init_done), .kick_pulse(kick_pulse), .eoi_pulse(eoi_pulse),
    .missed_cnt(missed_cnt), .err(err)
  );

  typedef struct { logic [7:0] addr; logic wr; logic [31:0] data; } xfer_t;
  typedef struct {
    logic pready; logic chk_bus;
    logic psel; logic penable; logic pwrite; logic init_done;
    logic [7:0] paddr; logic [31:0] pwdata;
  } init_vec_t;

  xfer_t exp_q[$];
  int n_vec = 0, n_miss = 0, cyc = 0;
  int hb_period = 0, hb_cnt = 0;
  int setup_cnt = 0, kick_cnt = 0, eoi_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic w, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.wr = w; x.data = d;
    exp_q.push_back(x);
  endtask

  // Every bus cycle is checked against the head of the expected-transfer queue.
  task automatic monitor();
    xfer_t e;
    if (!prst && psel) begin
      if (!penable) setup_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_xfer @cyc %0d: got addr %0h wr %0b, expected no transfer", cyc, paddr, pwrite);
      end else begin
        e = exp_q[0];
        if (e.wr) chk("xfer_wr", {paddr, pwrite, pwdata}, {e.addr, 1'b1, e.data});
        else      chk("xfer_rd", {paddr, pwrite}, {e.addr, 1'b0});
        if (penable && pready) void'(exp_q.pop_front());
      end
    end
    if (!prst && kick_pulse) kick_cnt++;
    if (!prst && eoi_pulse)  eoi_cnt++;
  endtask

  task automatic tick();
    @(negedge pclk);
    monitor();
    @(posedge pclk);
    #1;
    cyc++;
    if (hb_period > 0) begin
      hb_cnt++;
      heartbeat = (hb_cnt % hb_period == 0);
    end else begin
      heartbeat = 1'b0;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset(input int n);
    prst = 1'b1; pready = 1'b1; pslverr = 1'b0; wdt_int = 1'b0;
    hb_period = 0; hb_cnt = 0; heartbeat = 1'b0;
    repeat (n) tick();
    chk("reset_state", {psel, penable, pwrite, kick_pulse, eoi_pulse, init_done, err,
                        paddr, pwdata, missed_cnt}, 64'h0);
    exp_q.delete();
    setup_cnt = 0; kick_cnt = 0; eoi_cnt = 0;
    push(8'h04, 1'b1, 32'h0000_0000);
    push(8'h00, 1'b1, 32'h0000_0001);
    prst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    init_vec_t tbl [6];
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};

    // Init sequence, then a long heartbeat-free run to saturate the miss count.
    do_reset(3);
    for (int i = 0; i < 6; i++) begin
      tick();
      pready = tbl[i].pready;
      if (tbl[i].chk_bus)
        chk("init_bus", {psel, penable, pwrite, init_done, paddr, pwdata},
            {tbl[i].psel, tbl[i].penable, tbl[i].pwrite, tbl[i].init_done, tbl[i].paddr, tbl[i].pwdata});
      else
        chk("init_idle", {psel, penable, init_done}, {tbl[i].psel, tbl[i].penable, tbl[i].init_done});
    end
    run_to(20);   chk("missed_before_expiry", missed_cnt, 8'd0);
    run_to(21);   chk("missed_first_expiry", missed_cnt, 8'd1);
    run_to(4084); chk("missed_254", missed_cnt, 8'd254);
    run_to(4085); chk("missed_255", missed_cnt, 8'd255);
    run_to(4810); chk("missed_saturated", missed_cnt, 8'd255);
    chk("idle_setups", setup_cnt, 2);
    chk("idle_kicks", kick_cnt, 0);
    chk("idle_queue_empty", exp_q.size(), 0);

    // Periodic kicks with a heartbeat every 10 cycles.
    do_reset(2);
    hb_period = 10;
    repeat (8) push(8'h0C, 1'b1, 32'h0000_0076);
    while (cyc < 140) begin
      tick();
      chk("kick_timing", kick_pulse, (cyc >= 24) && ((cyc - 24) % 16 == 0));
    end
    chk("kick_count", kick_cnt, 8);
    chk("kick_missed_zero", missed_cnt, 8'd0);
    chk("kick_queue_empty", exp_q.size(), 0);

    // Interrupt arrives while a kick is pending: EOI first, stale level ignored.
    do_reset(2);
    push(8'h14, 1'b0, 32'h0);
    push(8'h0C, 1'b1, 32'h0000_0076);
    while (cyc < 40) begin
      tick();
      if (cyc == 6)  heartbeat = 1'b1;
      if (cyc == 21) wdt_int = 1'b1;
      if (cyc == 25) wdt_int = 1'b0;
      chk("eoi_timing", eoi_pulse, cyc == 24);
      chk("kick_after_eoi", kick_pulse, cyc == 27);
    end
    chk("eoi_count", eoi_cnt, 1);
    chk("eoi_kick_count", kick_cnt, 1);
    chk("eoi_missed_one", missed_cnt, 8'd1);
    chk("eoi_queue_empty", exp_q.size(), 0);

    // Wait states followed by a slave error on completion.
    do_reset(2);
    push(8'h0C, 1'b1, 32'h0000_0076);
    while (cyc < 40) begin
      tick();
      if (cyc == 6)  heartbeat = 1'b1;
      if (cyc == 22) pready = 1'b0;
      if (cyc == 28) begin pready = 1'b1; pslverr = 1'b1; end
      if (cyc == 29) pslverr = 1'b0;
      if (cyc >= 23 && cyc <= 28) chk("access_hold", {psel, penable}, 2'b11);
      chk("err_sticky", err, cyc >= 29);
      chk("kick_on_err", kick_pulse, cyc == 29);
    end
    chk("err_no_retry", setup_cnt, 3);
    chk("err_kick_count", kick_cnt, 1);
    chk("err_queue_empty", exp_q.size(), 0);

    // Reset during ACCESS aborts the transfer and reruns init.
    do_reset(2);
    push(8'h0C, 1'b1, 32'h0000_0076);
    while (cyc < 23) begin
      tick();
      if (cyc == 6)  heartbeat = 1'b1;
      if (cyc == 22) pready = 1'b0;
    end
    chk("pre_rst_access", {psel, penable}, 2'b11);
    prst = 1'b1;
    tick();
    chk("rst_mid_access", {psel, penable}, 2'b00);
    do_reset(2);
    tick();
    chk("reinit_setup", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b0, 1'b1, 8'h04, 32'h0});
    run_to(6);
    chk("reinit_done", init_done, 1'b1);
    chk("reinit_setups", setup_cnt, 2);
    chk("reinit_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wdt_apb_servicer.md
# wdt_apb_servicer

Autonomous APB initiator that drives the other end of the watchdog register interface: it programs the watchdog's TORR and CR registers after reset, then periodically writes the restart key to CRR. The restart is issued only while a system heartbeat keeps arming it. It also clears watchdog interrupts by reading EOI. It sits between an always-on health monitor and the watchdog's APB slave port, so the watchdog can be serviced without CPU involvement.

## Interface
Parameters:
- ADDR_W, 8, APB address width
- BASE_ADDR, 0, byte base address of the watchdog; register offsets are CR 0x00, TORR 0x04, CRR 0x0C, EOI 0x14
- TORR_VAL, 8'h00, value written to TORR during init
- CR_VAL, 6'h01, value written to CR during init; bit0 enables the watchdog
- KICK_PERIOD, 32'd1000, kick interval in pclk cycles, minimum 4

Ports:
- pclk  in  1  clock; all logic is on its rising edge
- prst  in  1  synchronous, active-high reset
- heartbeat  in  1  single-cycle health pulse that arms the next kick
- wdt_int  in  1  watchdog interrupt level
- psel / penable / pwrite  out  1 each  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data; ignored except to complete the read
- pready  in  1  slave ready
- pslverr  in  1  slave error
- init_done  out  1  high after both init writes complete
- kick_pulse  out  1  one cycle, on completion of a CRR write
- eoi_pulse  out  1  one cycle, on completion of an EOI read
- missed_cnt  out  8  count of period expiries with no heartbeat; saturates at 255
- err  out  1  sticky; set by pslverr on any completed transfer

## Operation
- Reset values:
  - psel, penable, pwrite, kick_pulse, eoi_pulse, init_done, err = 0.
  - paddr = 0, pwdata = 0, missed_cnt = 0.
  - armed = 0, kick_req = 0, period counter = KICK_PERIOD-1, holdoff = 0.
- FSM states: INIT_TORR, INIT_CR, IDLE, SETUP, ACCESS.
  - After reset, run INIT_TORR: write TORR_VAL to BASE+0x04.
  - Then run INIT_CR: write CR_VAL to BASE+0x00.
  - init_done is set on completion of the CR write; go to IDLE.
- Each transfer:
  - SETUP: psel=1, penable=0, for exactly 1 cycle.
  - ACCESS: psel=1, penable=1, held until pready=1.
  - Return to IDLE, or move to the next init state. psel falls in the cycle after completion.
  - paddr, pwrite and pwdata are stable from SETUP through the completing cycle.
- CRR write data is 32'h0000_0076. EOI is a read (pwrite=0) of BASE+0x14.
- Period counter:
  - Runs only when init_done=1.
  - Decrements each cycle. At 0 it reloads KICK_PERIOD-1.
  - On expiry with armed=1: set kick_req. On expiry with armed=0: missed_cnt+1, saturating.
- armed:
  - Set by heartbeat.
  - Cleared when a CRR write completes.
  - If heartbeat occurs in that same cycle, set wins.
- Arbitration in IDLE (transfer starts the next cycle):
  - EOI service when wdt_int=1 and holdoff=0. This has priority.
  - Otherwise CRR write when kick_req=1.
  - kick_req clears when its CRR transfer enters SETUP. If an expiry occurs while a kick is pending, no extra kick is queued.
- holdoff: a 2-cycle counter loaded on EOI completion. It blocks re-service of a stale wdt_int.
- pslverr completes the transfer normally, sets err, and is not retried.
- Reset mid-transfer: psel and penable are 0 on the next edge, all state is reinitialised, and init reruns.

## Timing
- Reset deasserted at edge 0: SETUP for TORR at cycle 1, ACCESS at cycle 2.
- With pready=1, init finishes in 4 cycles, and init_done=1 from cycle 5.
- Minimum transfer is 2 cycles, plus 1 IDLE cycle between non-init transfers.
- kick_pulse and eoi_pulse assert in the cycle after the completing ACCESS edge and last 1 cycle.
- Expiry-to-SETUP latency is 2 cycles when IDLE; otherwise it waits for the transfer in progress.

## Test plan
- Reset, pready=1 always → writes 0x00 to 0x04, then 0x01 to 0x00; init_done high at cycle 5; nothing else issued while heartbeat stays low.
- KICK_PERIOD=16 with a heartbeat every 10 cycles → CRR write of 0x76 to 0x0C once per 16 cycles; missed_cnt stays 0.
- No heartbeat for 300 expiries → no CRR writes; missed_cnt saturates at 255.
- wdt_int rises while a kick is pending → EOI read at 0x14 first, then the CRR write; eoi_pulse precedes kick_pulse; wdt_int still high for 1 cycle after EOI causes no second read.
- pready held low for 5 cycles with pslverr=1 on completion → signals stable through ACCESS, err sticky 1, no retry.
- prst asserted during ACCESS → psel=0 on the next edge, and the TORR init write is reissued after release.
